// File: rtl/display_mode_sequencer.sv
// Display-mode selector: synchronised, debounced forward/back buttons step a wrapping mode index.
// Optional DISPLAY_AUTO_RETURN_EN adds an idle timeout that returns the display to mode 0.
module display_mode_sequencer #(
    parameter int NUM_MODES       = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000,
    localparam int MODE_W         = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sw,
    input  logic                 sw_back,
    input  logic                 lock,
    output logic [MODE_W-1:0]    mode,
    output logic [NUM_MODES-1:0] enable,
    output logic                 mode_changed
);

    localparam int                DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

    if (NUM_MODES < 2 || DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("display_mode_sequencer: illegal parameter value");
    end

    // Bit 0 is the forward button, bit 1 the reverse button.
    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      stable;
    logic [1:0]      stable_q;
    logic [DB_W-1:0] db_cnt [2];

    assign raw = {sw_back, sw};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_q <= '0;
            for (int b = 0; b < 2; b++) db_cnt[b] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_q <= stable;
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] != stable[b]) begin
                    if (db_cnt[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        stable[b] <= sync2[b];
                        db_cnt[b] <= '0;
                    end else begin
                        db_cnt[b] <= db_cnt[b] + 1'b1;
                    end
                end else begin
                    db_cnt[b] <= '0;
                end
            end
        end
    end

    // A press is the debounced rising edge; lock discards it rather than deferring it.
    logic [1:0] press;
    logic       step_fwd;
    logic       step_back;

    assign press     = stable & ~stable_q & {2{~lock}};
    assign step_fwd  = press[0] & ~press[1];
    assign step_back = press[1] & ~press[0];

    logic timeout;

`ifdef DISPLAY_AUTO_RETURN_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt;

    assign timeout = (mode != '0) && !lock && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (step_fwd || step_back || timeout || mode == '0 || lock) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    logic [MODE_W-1:0]    next_mode;
    logic [NUM_MODES-1:0] next_enable;
    logic                 next_changed;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        next_mode    = mode;
        next_changed = 1'b0;
        if (step_fwd) begin
            next_mode    = (mode == LAST_MODE) ? '0 : mode + 1'b1;
            next_changed = 1'b1;
        end else if (step_back) begin
            next_mode    = (mode == '0) ? LAST_MODE : mode - 1'b1;
            next_changed = 1'b1;
        end else if (timeout) begin
            next_mode    = '0;
            next_changed = 1'b1;
        end
        next_enable = NUM_MODES'(1) << next_mode;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode         <= '0;
            enable       <= NUM_MODES'(1);
            mode_changed <= 1'b0;
        end else begin
            mode         <= next_mode;
            enable       <= next_enable;
            mode_changed <= next_changed;
        end
    end

endmodule

// File: tb/tb_display_mode_sequencer.sv
// Scoreboard bench for display_mode_sequencer: expected steps are queued when a press is driven
// and matched (mode, enable, arrival edge) whenever the DUT pulses mode_changed.
module tb_display_mode_sequencer;

    localparam int NM = 4;
    localparam int DB = 16;
    localparam int TO = 100;

    typedef struct {
        int mode;
        int at_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw = 1'b0;
    logic       sw_back = 1'b0;
    logic       lock = 1'b0;
    logic [1:0] mode;
    logic [3:0] enable;
    logic       mode_changed;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_mode = 0;
    int   pushed = 0;
    int   pulses = 0;
    exp_t sb_q[$];

    display_mode_sequencer #(
        .NUM_MODES      (NM),
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw          (sw),
        .sw_back     (sw_back),
        .lock        (lock),
        .mode        (mode),
        .enable      (enable),
        .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Scoreboard consumer: every mode_changed pulse must match the oldest queued step.
    always @(negedge clk) begin
        if (rst_n && mode_changed) begin
            pulses++;
            if (sb_q.size() == 0) begin
                check("spurious_pulse", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("step_mode", int'(mode), e.mode);
                check("step_enable", int'(enable), 1 << e.mode);
                check("step_edge", cyc, e.at_cyc);
            end
        end
    end

    task automatic press(input bit f, input bit b, input int hold, input int gap);
        int   n;
        int   nm;
        exp_t e;
        @(negedge clk);
        n       = cyc;
        sw      = f;
        sw_back = b;
        if (!lock && (f ^ b)) begin
            nm       = f ? (exp_mode + 1) % NM : (exp_mode + NM - 1) % NM;
            e.mode   = nm;
            e.at_cyc = n + DB + 3;
            sb_q.push_back(e);
            pushed++;
            exp_mode = nm;
`ifdef DISPLAY_AUTO_RETURN_EN
            if (nm != 0 && DB + 3 + TO <= hold + gap) begin
                e.mode   = 0;
                e.at_cyc = n + DB + 3 + TO;
                sb_q.push_back(e);
                pushed++;
                exp_mode = 0;
            end
`endif
        end
        repeat (hold) @(negedge clk);
        sw      = 1'b0;
        sw_back = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_mode", int'(mode), 0);
        check("reset_enable", int'(enable), 1);
        check("reset_changed", int'(mode_changed), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Four clean forward presses wrap 1,2,3,0.
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 40, 20);
        check("wrap_mode", int'(mode), exp_mode);

        // A 10-cycle glitch never reaches the debounced level.
        @(negedge clk);
        sw = 1'b1;
        repeat (10) @(negedge clk);
        sw = 1'b0;
        repeat (40) @(negedge clk);
        check("glitch_mode", int'(mode), exp_mode);

        // A long hold produces exactly one step; release produces none.
        press(1'b1, 1'b0, 500, 20);
        check("hold_mode", int'(mode), exp_mode);

        while (exp_mode != 0) press(1'b1, 1'b0, 30, 20);
        press(1'b0, 1'b1, 30, 20);
        check("back_wrap_mode", int'(mode), 3);

        press(1'b1, 1'b1, 40, 10);
        check("simultaneous_mode", int'(mode), 3);

        @(negedge clk);
        lock = 1'b1;
        press(1'b1, 1'b0, 30, 20);
        lock = 1'b0;
        repeat (30) @(negedge clk);
        check("lock_mode", int'(mode), 3);

        // Reach mode 2 and leave it idle.
        press(1'b1, 1'b0, 30, 20);
        press(1'b1, 1'b0, 30, 20);
        press(1'b1, 1'b0, 30, 1000);
        check("idle_mode", int'(mode), exp_mode);
        check("queue_drained", sb_q.size(), 0);

        // Asynchronous reset in the middle of a debounce.
        @(negedge clk);
        sw = 1'b1;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_mode", int'(mode), 0);
        check("async_reset_enable", int'(enable), 1);
        check("async_reset_changed", int'(mode_changed), 0);
        exp_mode = 0;
        @(negedge clk);
        sw    = 1'b0;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_reset_mode", int'(mode), 0);
        check("post_reset_enable", int'(enable), 1);

        check("pulse_count", pulses, pushed);
        check("queue_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_mode_sequencer.md
Name: display_mode_sequencer

Overview:
Parametrised display-mode selector for the clock/stopwatch display path. It takes raw forward/back push-buttons, synchronises and debounces them, and steps through NUM_MODES display modes. It drives a binary mode index and a one-hot enable vector to the display sources. Mode 0 is the time display (enable[0]=1 after reset).

Parameters:
NUM_MODES, 4, number of display modes (>=2); mode index wraps within 0..NUM_MODES-1
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a level change on a button (>=1)
TIMEOUT_CYCLES, 1000, idle cycles before auto-return to mode 0 (used only with DISPLAY_AUTO_RETURN_EN; >=1)
MODE_W, $clog2(NUM_MODES), derived localparam, width of mode index

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
sw  input  1  raw forward button, asynchronous, active-high
sw_back  input  1  raw reverse button, asynchronous, active-high
lock  input  1  synchronous; high = ignore presses, hold current mode
mode  output  MODE_W  current mode index, registered
enable  output  NUM_MODES  one-hot of mode, registered; enable[i]=1 iff mode==i
mode_changed  output  1  one-cycle pulse, high in the cycle mode takes a new value

Behaviour:
- Reset (rst_n low, async): mode=0, enable=1 (bit 0 only), mode_changed=0; synchronisers, stable levels, debounce counters, idle counter all cleared to 0.
- Per button: 2-flop synchroniser -> debounce -> rising-edge detect of debounced level -> press pulse.
- Debounce: counter increments each cycle synchronised level != stable level; cleared in any cycle they are equal; when count reaches DEBOUNCE_CYCLES, stable level takes synchronised value and counter clears. Pulses shorter than DEBOUNCE_CYCLES cycles never change stable level.
- Latency: sw driven 1 and held; counting the first clk edge sampling 1 as edge 1, mode/enable/mode_changed update at edge DEBOUNCE_CYCLES+3. Same for sw_back.
- Only rising edge of debounced level is a press; holding a button produces exactly one step; release produces none.
- Forward press: mode = (mode==NUM_MODES-1) ? 0 : mode+1.
- Back press: mode = (mode==0) ? NUM_MODES-1 : mode-1.
- Forward and back press in same cycle: no change, no mode_changed.
- lock high in the press cycle: press discarded (not queued); debounce continues so releasing lock does not generate a step.
- enable and mode always updated in the same edge; enable never zero or multi-hot.
- mode_changed high exactly one cycle per accepted step; never high when mode unchanged.
- Reset mid-debounce discards pending press.

Optional Feature:
Macro DISPLAY_AUTO_RETURN_EN.
- Defined: idle counter counts cycles while mode!=0 and lock=0; cleared on accepted press, while mode==0, or while lock=1. Reaching TIMEOUT_CYCLES sets mode=0, enable=1, pulses mode_changed, clears counter. A press in the timeout cycle takes priority; no return that cycle.
- Undefined: no idle counter logic; mode holds indefinitely; TIMEOUT_CYCLES unused.

Test Plan:
- Reset: assert rst_n=0 mid-run with mode=2 -> mode=0, enable=4'b0001, mode_changed=0 immediately without clock edge.
- Forward wrap (NUM_MODES=4, DEBOUNCE_CYCLES=16): 4 clean presses, each held 40 cycles -> mode 1,2,3,0; enable 0010,0100,1000,0001; each update at edge 19 after press start; 4 mode_changed pulses.
- Glitch/hold: sw high 10 cycles -> no change; sw held 500 cycles -> single step 0->1.
- Reverse and simultaneous: from mode 0 back press -> mode 3; sw and sw_back raised same cycle, held 40 -> mode stays 3, no mode_changed.
- Lock: lock=1, forward press, release, lock=0 -> mode unchanged, no pulse.
- Auto-return (macro defined, TIMEOUT_CYCLES=100): step to mode 2, idle -> mode=0 and mode_changed pulse exactly 100 cycles after step; macro undefined -> mode stays 2 after 1000 cycles.
